gen_res_ttl_pulse: RTL

Generator side of the TTL result-pulse interface. It drives a burst of programmable-width TTL pulses on res_ttl1_out. Each pulse is aligned to a rising edge of the 1 MHz reference, and all logic runs on the 100 MHz system clock. It feeds the result-TTL checker input on the test bench board, so the checker's falling-edge and pulse-width counting can be exercised against known widths.

---
 rtl/gen_res_ttl_pulse.sv | 116 +++++++++++
 1 files changed

// File: rtl/gen_res_ttl_pulse.sv
// Burst generator for programmable-width TTL result pulses. Each rising edge is
// aligned to a rising edge of the 1 MHz reference; all logic runs on clk_100Mz.
module gen_res_ttl_pulse #(
  parameter int WIDTH_W = 8,
  parameter int GAP_W   = 8,
  parameter int NUM_W   = 8
) (
  input  logic               clk_100Mz,
  input  logic               rst,
  input  logic               clk_1Mz,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH_W-1:0] width_cfg,
  input  logic [GAP_W-1:0]   gap_cfg,
  input  logic [NUM_W-1:0]   num_cfg,
  output logic               res_ttl1_out,
  output logic               busy,
  output logic               done,
  output logic [NUM_W-1:0]   pulses_sent
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic               buff_refresh;
  logic               tick;
  logic               accept;
  logic               abort;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] high_cnt;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_W-1:0]   num_q;
  logic [NUM_W-1:0]   sent_next;

  // buff_refresh powers up high so a reference already high at reset release is not a tick
  assign tick      = ~buff_refresh & clk_1Mz;
  assign accept    = (state == S_IDLE) & start & ~stop;
  assign abort     = stop & ((state == S_WAIT) | (state == S_HIGH) | (state == S_GAP));
  assign sent_next = pulses_sent + 1'b1;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk_100Mz) begin
    if (rst) buff_refresh <= 1'b1;
    else     buff_refresh <= clk_1Mz;
  end

  always_ff @(posedge clk_100Mz) begin
    if (accept) begin
      width_q <= width_cfg;
      gap_q   <= gap_cfg;
      num_q   <= num_cfg;
    end
  end

  always_ff @(posedge clk_100Mz) begin
    if (rst) begin
      state        <= S_IDLE;
      res_ttl1_out <= 1'b0;
      pulses_sent  <= '0;
      high_cnt     <= '0;
      gap_cnt      <= '0;
    end else if (abort) begin
      res_ttl1_out <= 1'b0;
      state        <= S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pulses_sent <= '0;
            if ((width_cfg == '0) || (num_cfg == '0)) state <= S_DONE;
            else                                      state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tick) begin
            high_cnt     <= width_q - 1'b1;
            res_ttl1_out <= 1'b1;
            state        <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (high_cnt == '0) begin
            res_ttl1_out <= 1'b0;
            pulses_sent  <= sent_next;
            if (sent_next == num_q) begin
              state <= S_DONE;
            end else begin
              gap_cnt <= gap_q;
              state   <= S_GAP;
            end
          end else begin
            high_cnt <= high_cnt - 1'b1;
          end
        end
        S_GAP: begin
          // gap is counted in reference ticks seen only after the pulse has ended
          if (gap_cnt == '0) begin
            state <= S_WAIT;
          end else if (tick) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == GAP_W'(1)) state <= S_WAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
